instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset; the clock port is clk and the reset port is reset.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk, in, 1, rising-edge clock.
- reset, in, 1, synchronous active-high reset.
- start, in, 1, one-cycle pulse that begins a program load.
- in_valid, in, 1, an instruction request is present.
- in_ready, out, 1, the request is accepted this cycle.
- in_op, in, 4, symbolic operation: 0 NOP, 1 ADDU, 2 SUBU, 3 ORI, 4 LW, 5 SW, 6 BEQ, 7 LUI, 8 JAL, 9 JR, 10-15 illegal.
- in_rs / in_rt / in_rd, in, 5 each, register fields.
- in_imm, in, 16, immediate / offset.
- in_target, in, 26, JAL target.
- in_last, in, 1, marks the final instruction of the program.
- im_we, out, 1, instruction-memory write enable.
- im_addr, out, 10, word address.
- im_wdata, out, 32, encoded MIPS word.
- busy, out, 1, FSM is in LOAD.
- done, out, 1, FSM is in DONE.
- full, out, 1, all 1024 words have been written.
- err, out, 1, sticky illegal-op flag; present only when ENC_ERR_CHECK_EN is defined.

Function
REQ-003 SHALL implement the FSM IDLE -> LOAD -> DONE:
- IDLE -> LOAD on start.
- LOAD -> DONE on the write of an in_last word, or on the write of word 1023.
- DONE -> LOAD on start.
REQ-004 SHALL drive in_ready = (state == LOAD); a transfer occurs when in_valid && in_ready.
REQ-005 SHALL register each accepted request and assert im_we for exactly the following cycle, with im_addr and im_wdata valid in that same cycle (latency 1).
REQ-006 SHALL set im_addr of the first write after start to 0 and increment it by 1 after every write.
REQ-007 SHALL sustain one write per cycle under continuous in_valid.
REQ-008 SHALL encode as follows:
- ADDU = {000000, rs, rt, rd, 00000, 100001}.
- SUBU = the same as ADDU with funct 100011.
- JR = {000000, rs, 15'b0, 001000}.
- ORI = {001101, rs, rt, imm}.
- LW = {100011, rs, rt, imm}.
- SW = {101011, rs, rt, imm}.
- BEQ = {000100, rs, rt, imm}.
- LUI = {001111, 00000, rt, imm}.
- JAL = {000011, target}.
- NOP = 32'h0.
REQ-009 SHALL ignore fields an op does not use (e.g. in_rd for ORI).
REQ-010 SHALL assert full after the write to address 1023 and hold it until the next start or reset; in_ready SHALL be 0 while full.
REQ-011 SHALL give start priority when start and a transfer coincide in LOAD: the request is not accepted (in_ready = 0 that cycle), the address restarts at 0, and full is cleared.
REQ-012 SHALL still complete a write already registered when start arrives, at its original address.
REQ-013 SHALL hold done until the next start.
REQ-014 SHALL ignore in_valid in IDLE and DONE (no write, in_ready = 0).

Reset
REQ-015 SHALL, on reset, set state = IDLE and im_we = 0, im_addr = 0, im_wdata = 0, in_ready = 0, busy = 0, done = 0, full = 0, err = 0.
REQ-016 SHALL, on reset mid-LOAD, abandon any pending write (no im_we the following cycle).

Configuration
REQ-017 SHALL, with ENC_ERR_CHECK_EN defined:
- drop an illegal op (no write, no address increment);
- set err sticky until start or reset;
- still complete an in_last transfer that carries an illegal op as LOAD -> DONE.
REQ-018 SHALL, without ENC_ERR_CHECK_EN, have no err port and encode illegal ops as NOP (32'h0), written normally.

Structure
REQ-019 SHALL place in package instr_enc_pkg: the op enumeration, the opcode/funct constants, and IM_DEPTH = 1024.
REQ-020 SHALL implement field packing in one combinational sub-module, instr_pack (in_op and fields -> 32-bit word plus an illegal flag); the FSM, counter and registers stay in instr_encoder.

Verification
REQ-021 SHALL cover these directed scenarios:
- start, then ADDU rs=1 rt=2 rd=3 -> next cycle im_we=1, im_addr=0, im_wdata=0x00221821.
- Back-to-back ORI rs=0 rt=1 imm=0x1234, then LUI rt=1 imm=0xFFFF, then SW rs=0 rt=2 imm=4 -> writes 0x34011234, 0x3C01FFFF, 0xAC020004 at addresses 0, 1, 2 on consecutive cycles.
- JAL target=0xC03, then JR rs=31 with in_last -> writes 0x0C000C03, 0x03E00008; done=1, busy=0, in_ready=0.
- 1024 continuous NOPs -> last write at im_addr=1023, full=1, state DONE, 1025th request not accepted.
- start coincident with in_valid mid-LOAD, then reset mid-LOAD -> request not accepted, next write at address 0; after reset all outputs 0 and no im_we.
- in_op=12:
  - ENC_ERR_CHECK_EN defined -> no write, err=1, address unchanged;
  - undefined -> im_wdata=0x00000000 written.

Source files
------------

// File: rtl/instr_enc_pkg.sv
// Shared types and encoding constants for the MIPS program loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package instr_enc_pkg;

   localparam int IM_DEPTH = 1024;
   localparam int IM_AW    = $clog2(IM_DEPTH);

   // Symbolic operations presented on in_op; 10..15 are illegal.
   typedef enum logic [3:0] {
      OP_NOP  = 4'd0,
      OP_ADDU = 4'd1,
      OP_SUBU = 4'd2,
      OP_ORI  = 4'd3,
      OP_LW   = 4'd4,
      OP_SW   = 4'd5,
      OP_BEQ  = 4'd6,
      OP_LUI  = 4'd7,
      OP_JAL  = 4'd8,
      OP_JR   = 4'd9
   } op_e;

   // Primary opcodes.
   localparam logic [5:0] OPC_SPECIAL = 6'b000000;
   localparam logic [5:0] OPC_ORI     = 6'b001101;
   localparam logic [5:0] OPC_LW      = 6'b100011;
   localparam logic [5:0] OPC_SW      = 6'b101011;
   localparam logic [5:0] OPC_BEQ     = 6'b000100;
   localparam logic [5:0] OPC_LUI     = 6'b001111;
   localparam logic [5:0] OPC_JAL     = 6'b000011;

   // SPECIAL funct codes.
   localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
   localparam logic [5:0] FUNCT_SUBU  = 6'b100011;
   localparam logic [5:0] FUNCT_JR    = 6'b001000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // One symbolic instruction request as seen by the packer.
   typedef struct packed {
      logic [3:0]  op;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [15:0] imm;
      logic [25:0] target;
   } req_t;

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational packer: symbolic request -> 32-bit MIPS word plus illegal-op flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; result valid whenever the request fields are.
module instr_pack
   import instr_enc_pkg::*;
(
   input  req_t        req,
   output logic [31:0] word,
   output logic        illegal
);

   // Field packing per operation; fields an op does not use are simply not referenced.
   always_comb begin
      word    = 32'h0;
      illegal = 1'b0;
      case (req.op)
         OP_NOP:  word = 32'h0;
         OP_ADDU: word = {OPC_SPECIAL, req.rs, req.rt, req.rd, 5'b00000, FUNCT_ADDU};
         OP_SUBU: word = {OPC_SPECIAL, req.rs, req.rt, req.rd, 5'b00000, FUNCT_SUBU};
         OP_ORI:  word = {OPC_ORI, req.rs, req.rt, req.imm};
         OP_LW:   word = {OPC_LW,  req.rs, req.rt, req.imm};
         OP_SW:   word = {OPC_SW,  req.rs, req.rt, req.imm};
         OP_BEQ:  word = {OPC_BEQ, req.rs, req.rt, req.imm};
         OP_LUI:  word = {OPC_LUI, 5'b00000, req.rt, req.imm};
         OP_JAL:  word = {OPC_JAL, req.target};
         OP_JR:   word = {OPC_SPECIAL, req.rs, 15'b0, FUNCT_JR};
         default: begin
            word    = 32'h0;
            illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: encodes symbolic requests into MIPS words and streams them into instruction memory; ENC_ERR_CHECK_EN adds illegal-op dropping and a sticky err port.
// Latency: 1 cycle from accepted request to im_we/im_addr/im_wdata.
// Backpressure: in_ready only in LOAD, low while full or during a start pulse; one write per cycle sustained.
module instr_encoder
   import instr_enc_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_op,
   input  logic [4:0]  in_rs,
   input  logic [4:0]  in_rt,
   input  logic [4:0]  in_rd,
   input  logic [15:0] in_imm,
   input  logic [25:0] in_target,
   input  logic        in_last,
   output logic        im_we,
   output logic [9:0]  im_addr,
   output logic [31:0] im_wdata,
   output logic        busy,
   output logic        done,
`ifdef ENC_ERR_CHECK_EN
   output logic        err,
`endif
   output logic        full
);

   state_e            state_q;
   state_e            state_d;
   logic [IM_AW-1:0]  wr_ptr_q;
   logic              xfer;
   logic              wr_acc;
   logic              at_top;
   req_t              req_dat;
   logic [31:0]       pack_word;
   logic              pack_illegal;
   logic [31:0]       wdata_sel;

   assign req_dat = '{op: in_op, rs: in_rs, rt: in_rt, rd: in_rd,
                      imm: in_imm, target: in_target};

   instr_pack u_pack (
      .req     (req_dat),
      .word    (pack_word),
      .illegal (pack_illegal)
   );

   // start wins over a coincident transfer, so it also masks in_ready.
   assign in_ready = (state_q == ST_LOAD) && !full && !start;
   assign xfer     = in_valid && in_ready;
   assign at_top   = (wr_ptr_q == IM_AW'(IM_DEPTH - 1));
   assign busy     = (state_q == ST_LOAD);
   assign done     = (state_q == ST_DONE);

`ifdef ENC_ERR_CHECK_EN
   // Illegal ops are consumed but never written.
   assign wr_acc    = xfer && !pack_illegal;
   assign wdata_sel = pack_word;
`else
   // Illegal ops go to memory as NOP.
   assign wr_acc    = xfer;
   assign wdata_sel = pack_illegal ? 32'h0 : pack_word;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next state: an in_last transfer ends the load even if it was dropped; the top word ends it only when written.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_LOAD;
         ST_LOAD: if ((xfer && in_last) || (wr_acc && at_top)) state_d = ST_DONE;
         ST_DONE: if (start) state_d = ST_LOAD;
         default: state_d = ST_IDLE;
      endcase
   end

   // Write port, address counter and full flag; a write registered before start still drains at its own address.
   always_ff @(posedge clk) begin
      if (reset) begin
         im_we    <= 1'b0;
         im_addr  <= '0;
         im_wdata <= 32'h0;
         wr_ptr_q <= '0;
         full     <= 1'b0;
      end else begin
         im_we <= wr_acc;
         if (wr_acc) begin
            im_addr  <= wr_ptr_q;
            im_wdata <= wdata_sel;
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (start) begin
            wr_ptr_q <= '0;
         end
         if (start)                full <= 1'b0;
         else if (wr_acc && at_top) full <= 1'b1;
      end
   end

`ifdef ENC_ERR_CHECK_EN
   // Sticky illegal-op flag, cleared by the next program load.
   always_ff @(posedge clk) begin
      if (reset)                     err <= 1'b0;
      else if (start)                err <= 1'b0;
      else if (xfer && pack_illegal) err <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Compile with or without ENC_ERR_CHECK_EN to match the DUT build.
module tb_instr_encoder;

   logic        clk;
   logic        reset;
   logic        start;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_op;
   logic [4:0]  in_rs;
   logic [4:0]  in_rt;
   logic [4:0]  in_rd;
   logic [15:0] in_imm;
   logic [25:0] in_target;
   logic        in_last;
   logic        im_we;
   logic [9:0]  im_addr;
   logic [31:0] im_wdata;
   logic        busy;
   logic        done;
   logic        full;
`ifdef ENC_ERR_CHECK_EN
   logic        err;
`endif

   int checks   = 0;
   int failures = 0;

   instr_encoder dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_rs     (in_rs),
      .in_rt     (in_rt),
      .in_rd     (in_rd),
      .in_imm    (in_imm),
      .in_target (in_target),
      .in_last   (in_last),
      .im_we     (im_we),
      .im_addr   (im_addr),
      .im_wdata  (im_wdata),
      .busy      (busy),
      .done      (done),
`ifdef ENC_ERR_CHECK_EN
      .err       (err),
`endif
      .full      (full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                        input logic last);
      in_valid  = 1'b1;
      in_op     = op;
      in_rs     = rs;
      in_rt     = rt;
      in_rd     = rd;
      in_imm    = imm;
      in_target = tgt;
      in_last   = last;
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0; in_op = 4'd0; in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0;
      in_imm = 16'h0; in_target = 26'h0; in_last = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; idle_inputs();
      tick(); tick();
      checks++; if (im_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%0b exp=0", im_we); end
      checks++; if (im_addr !== 10'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", im_addr); end
      checks++; if (im_wdata !== 32'h0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", im_wdata); end
      checks++; if ({in_ready, busy, done, full} !== 4'b0000) begin failures++;
         $display("FAIL reset_flags got rdy/busy/done/full=%b exp=0000", {in_ready, busy, done, full}); end
`ifdef ENC_ERR_CHECK_EN
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", err); end
`endif
      // in_valid in IDLE is ignored.
      reset = 1'b0;
      drive(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL idle_ready got=%0b exp=0", in_ready); end
      tick();
      checks++; if (im_we !== 1'b0) begin failures++; $display("FAIL idle_we got=%0b exp=0", im_we); end
      idle_inputs();
   endtask

   task automatic test_addu();
      pulse_start();
      drive(4'd1, 5'd1, 5'd2, 5'd3, 16'hFFFF, 26'h3FFFFFF, 1'b0);
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL addu_ready got=%0b exp=1", in_ready); end
      tick();
      idle_inputs();
      checks++; if (im_we !== 1'b1 || im_addr !== 10'd0 || im_wdata !== 32'h00221821) begin failures++;
         $display("FAIL addu_write got we=%0b addr=%0d data=%h exp we=1 addr=0 data=00221821", im_we, im_addr, im_wdata); end
      tick();
      checks++; if (im_we !== 1'b0) begin failures++; $display("FAIL addu_we_drop got=%0b exp=0", im_we); end
   endtask

   task automatic test_back_to_back();
      logic [3:0]  ops  [3] = '{4'd3, 4'd7, 4'd5};
      logic [4:0]  rss  [3] = '{5'd0, 5'd9, 5'd0};
      logic [4:0]  rts  [3] = '{5'd1, 5'd1, 5'd2};
      logic [15:0] imms [3] = '{16'h1234, 16'hFFFF, 16'h0004};
      logic [31:0] exps [3] = '{32'h34011234, 32'h3C01FFFF, 32'hAC020004};
      pulse_start();
      for (int i = 0; i < 3; i++) begin
         drive(ops[i], rss[i], rts[i], 5'd31, imms[i], 26'h0, 1'b0);
         tick();
         checks++; if (im_we !== 1'b1 || im_addr !== 10'(i) || im_wdata !== exps[i]) begin failures++;
            $display("FAIL b2b_%0d got we=%0b addr=%0d data=%h exp we=1 addr=%0d data=%h",
                     i, im_we, im_addr, im_wdata, i, exps[i]); end
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_jal_jr_last();
      pulse_start();
      drive(4'd8, 5'd4, 5'd5, 5'd6, 16'h7777, 26'h0000C03, 1'b0);
      tick();
      checks++; if (im_we !== 1'b1 || im_addr !== 10'd0 || im_wdata !== 32'h0C000C03) begin failures++;
         $display("FAIL jal got we=%0b addr=%0d data=%h exp we=1 addr=0 data=0C000C03", im_we, im_addr, im_wdata); end
      drive(4'd9, 5'd31, 5'd7, 5'd7, 16'h5555, 26'h1, 1'b1);
      tick();
      checks++; if (im_we !== 1'b1 || im_addr !== 10'd1 || im_wdata !== 32'h03E00008) begin failures++;
         $display("FAIL jr got we=%0b addr=%0d data=%h exp we=1 addr=1 data=03E00008", im_we, im_addr, im_wdata); end
      checks++; if ({done, busy, in_ready} !== 3'b100) begin failures++;
         $display("FAIL last_done got done/busy/rdy=%b exp=100", {done, busy, in_ready}); end
      // Still valid in DONE: ignored, done held.
      tick();
      checks++; if (im_we !== 1'b0 || done !== 1'b1) begin failures++;
         $display("FAIL done_ignore got we=%0b done=%0b exp we=0 done=1", im_we, done); end
      idle_inputs();
   endtask

   task automatic test_full();
      int bad = 0;
      pulse_start();
      drive(4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0);
      for (int i = 0; i < 1024; i++) begin
         tick();
         if (im_we !== 1'b1 || im_addr !== 10'(i) || im_wdata !== 32'h0) bad++;
         if (i < 1023 && (full !== 1'b0 || done !== 1'b0)) bad++;
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL full_stream got bad_cycles=%0d exp=0", bad); end
      checks++; if (im_addr !== 10'd1023) begin failures++; $display("FAIL full_last_addr got=%0d exp=1023", im_addr); end
      checks++; if ({full, done, busy, in_ready} !== 4'b1100) begin failures++;
         $display("FAIL full_flags got full/done/busy/rdy=%b exp=1100", {full, done, busy, in_ready}); end
      tick();
      checks++; if (im_we !== 1'b0 || full !== 1'b1) begin failures++;
         $display("FAIL full_1025 got we=%0b full=%0b exp we=0 full=1", im_we, full); end
      idle_inputs();
      pulse_start();
      checks++; if (full !== 1'b0 || busy !== 1'b1) begin failures++;
         $display("FAIL full_clear got full=%0b busy=%0b exp full=0 busy=1", full, busy); end
   endtask

   task automatic test_restart_and_reset();
      pulse_start();
      drive(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
      tick();
      drive(4'd2, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
      tick();
      // start collides with a valid request while word 1 is on the write port.
      start = 1'b1;
      drive(4'd3, 5'd2, 5'd3, 5'd0, 16'h00FF, 26'h0, 1'b0);
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL restart_ready got=%0b exp=0", in_ready); end
      checks++; if (im_we !== 1'b1 || im_addr !== 10'd1 || im_wdata !== 32'h00221823) begin failures++;
         $display("FAIL restart_pending got we=%0b addr=%0d data=%h exp we=1 addr=1 data=00221823", im_we, im_addr, im_wdata); end
      tick();
      start = 1'b0;
      checks++; if (im_we !== 1'b0) begin failures++; $display("FAIL restart_noacc got=%0b exp=0", im_we); end
      tick();
      checks++; if (im_we !== 1'b1 || im_addr !== 10'd0 || im_wdata !== 32'h344300FF) begin failures++;
         $display("FAIL restart_addr0 got we=%0b addr=%0d data=%h exp we=1 addr=0 data=344300FF", im_we, im_addr, im_wdata); end
      // Reset mid-LOAD with a request that would otherwise be accepted.
      reset = 1'b1;
      drive(4'd4, 5'd1, 5'd1, 5'd1, 16'h0010, 26'h0, 1'b0);
      tick();
      checks++; if ({im_we, in_ready, busy, done, full} !== 5'b0 || im_addr !== 10'd0 || im_wdata !== 32'h0) begin failures++;
         $display("FAIL midload_reset got we/rdy/busy/done/full=%b addr=%0d data=%h exp 00000 0 0",
                  {im_we, in_ready, busy, done, full}, im_addr, im_wdata); end
      reset = 1'b0;
      idle_inputs();
      tick();
      checks++; if (im_we !== 1'b0 || busy !== 1'b0) begin failures++;
         $display("FAIL post_reset got we=%0b busy=%0b exp 0 0", im_we, busy); end
   endtask

   task automatic test_illegal();
      pulse_start();
      drive(4'd12, 5'd5, 5'd6, 5'd7, 16'hBEEF, 26'h2AAAAAA, 1'b0);
      tick();
`ifdef ENC_ERR_CHECK_EN
      checks++; if (im_we !== 1'b0 || err !== 1'b1) begin failures++;
         $display("FAIL illegal_drop got we=%0b err=%0b exp we=0 err=1", im_we, err); end
      drive(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
      tick();
      checks++; if (im_we !== 1'b1 || im_addr !== 10'd0 || err !== 1'b1) begin failures++;
         $display("FAIL illegal_addr got we=%0b addr=%0d err=%0b exp we=1 addr=0 err=1", im_we, im_addr, err); end
      drive(4'd15, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b1);
      tick();
      checks++; if (im_we !== 1'b0 || done !== 1'b1) begin failures++;
         $display("FAIL illegal_last got we=%0b done=%0b exp we=0 done=1", im_we, done); end
      idle_inputs();
      pulse_start();
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_clear got=%0b exp=0", err); end
`else
      checks++; if (im_we !== 1'b1 || im_addr !== 10'd0 || im_wdata !== 32'h0) begin failures++;
         $display("FAIL illegal_nop got we=%0b addr=%0d data=%h exp we=1 addr=0 data=00000000", im_we, im_addr, im_wdata); end
      drive(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
      tick();
      checks++; if (im_we !== 1'b1 || im_addr !== 10'd1 || im_wdata !== 32'h00221821) begin failures++;
         $display("FAIL illegal_next got we=%0b addr=%0d data=%h exp we=1 addr=1 data=00221821", im_we, im_addr, im_wdata); end
`endif
      idle_inputs();
      tick();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_addu();
      test_back_to_back();
      test_jal_jr_last();
      test_full();
      test_restart_and_reset();
      test_illegal();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
